prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter Psize, default 6: program-memory address width; 2^Psize words.
REQ-002 Parameter Isize, default 17: instruction width; SHALL be 9..24.
REQ-003 clk  input  1: single clock; all state on rising edge.
REQ-004 nReset  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: one-cycle request to begin a load.
REQ-006 data_in  input  8: serial byte stream from host.
REQ-007 data_valid  input  1: data_in valid this cycle.
REQ-008 data_ready  output  1: loader accepts a byte this cycle.
REQ-009 wr_en  output  1: program-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  Psize: program-memory write address.
REQ-011 wr_data  output  Isize: instruction word to write.
REQ-012 busy  output  1: load in progress; holds the CPU in reset.
REQ-013 load_done  output  1: last load completed; sticky until next start.

Function
REQ-014 Byte transfer SHALL occur only on a cycle with data_valid=1 and data_ready=1; data_in is ignored on all other cycles.
REQ-015 States SHALL be IDLE, HDR, RECV, WRITE, DONE.
REQ-016 IDLE/DONE: start=1 -> HDR next cycle; busy=1 and load_done=0 from that cycle; wr_addr is cleared to 0.
REQ-017 HDR: data_ready=1; the accepted byte L SHALL set the word count N = L if 1<=L<=2^Psize, else N = 2^Psize; -> RECV.
REQ-018 RECV: data_ready=1; K = ceil(Isize/8) bytes per word, MSB byte first; the first byte's unused upper bits are ignored (Isize=17: byte0[0]=I[16], byte1=I[15:8], byte2=I[7:0]).
REQ-019 After the K-th byte is accepted: -> WRITE; data_ready=0 in WRITE.
REQ-020 WRITE: wr_en=1 for exactly one cycle, with wr_data = the assembled word and wr_addr = the current word index.
REQ-021 After WRITE: if the index equals N-1 -> DONE, else the index increments and the state -> RECV.
REQ-022 Word-to-word throughput SHALL be K+1 cycles minimum; stalls on data_valid=0 SHALL be unbounded with no data loss.
REQ-023 DONE: busy=0, load_done=1, data_ready=0, and wr_addr holds N-1.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 Outside WRITE: wr_en=0, and wr_data holds its last value.
REQ-026 wr_addr SHALL never exceed 2^Psize-1; no wrap occurs because N <= 2^Psize.

Reset
REQ-027 nReset=0 SHALL immediately force state=IDLE, data_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, load_done=0, and clear the byte counter and assembly register.
REQ-028 Reset mid-load SHALL abandon the load; words already written are not revoked; no wr_en SHALL occur until a new start.
REQ-029 Release of nReset SHALL not itself start a load.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: output chk_err (1 bit, reset 0) is added; after the last WRITE the FSM enters state CHK with data_ready=1.
REQ-031 With PROG_LOADER_CHECKSUM_EN defined, the byte accepted in CHK SHALL equal the XOR of the header byte and all data bytes; on mismatch chk_err=1 in DONE.
REQ-032 With PROG_LOADER_CHECKSUM_EN defined, chk_err SHALL clear on start.
REQ-033 Macro undefined: no CHK state and no chk_err port; the FSM goes from WRITE straight to DONE.

Verification
REQ-034 Defaults, start, bytes 02,01,23,45,00,AB,CD back-to-back -> writes (addr0,0x12345), (addr1,0x0ABCD); load_done=1; busy=0.
REQ-035 Header 00 and header 0x80, 192 data bytes -> exactly 64 wr_en pulses at addresses 0..63; no 65th write.
REQ-036 data_valid toggled 1/0 every cycle during RECV -> identical wr_data/wr_addr sequence; data_ready=0 on every WRITE cycle.
REQ-037 nReset pulsed after the 2nd byte of word 3 -> all outputs 0 asynchronously; later start, 01,01,FF,FF -> single write addr0 = 0x1FFFF.
REQ-038 start pulsed during RECV -> ignored; load completes unchanged.
REQ-039 With PROG_LOADER_CHECKSUM_EN: 01,00,00,07 then checksum 06 -> chk_err=0; checksum 07 -> chk_err=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Host byte-stream and program-memory write bus of the program loader.
// Optional checksum status (chk_err) exists only when PROG_LOADER_CHECKSUM_EN
// is defined.
interface prog_loader_if #(
   parameter int Psize = 6,
   parameter int Isize = 17
);
   logic             start;
   logic [7:0]       data_in;
   logic             data_valid;
   logic             data_ready;
   logic             wr_en;
   logic [Psize-1:0] wr_addr;
   logic [Isize-1:0] wr_data;
   logic             busy;
   logic             load_done;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic             chk_err;
`endif

   // Host / boot controller side
   modport master (
      output start,
      output data_in,
      output data_valid,
      input  data_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  busy,
`ifdef PROG_LOADER_CHECKSUM_EN
      input  chk_err,
`endif
      input  load_done
   );

   // Loader side
   modport slave (
      input  start,
      input  data_in,
      input  data_valid,
      output data_ready,
      output wr_en,
      output wr_addr,
      output wr_data,
      output busy,
`ifdef PROG_LOADER_CHECKSUM_EN
      output chk_err,
`endif
      output load_done
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte stream from a host and writes
// it, MSB byte first, into program memory one instruction word at a time.
// The CPU is held in reset (busy) for the duration of a load.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte (state CHK) and the chk_err status output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no load since reset; waiting for start
// S_HDR   | accepting the header byte (word count)
// S_RECV  | accepting the K bytes of the current instruction word
// S_WRITE | one-cycle program-memory write of the assembled word
// S_CHK   | accepting the checksum byte (checksum build only)
// S_DONE  | load finished; load_done held until the next start
module prog_loader #(
   parameter int Psize = 6,
   parameter int Isize = 17
) (
   input  logic          clk,
   input  logic          nReset,
   prog_loader_if.slave  bus
);

   localparam int          K         = (Isize + 7) / 8;
   localparam logic [31:0] MEM_WORDS = 32'd1 << Psize;
   localparam logic [1:0]  LAST_BYTE = 2'(K - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_RECV  = 3'd2,
      S_WRITE = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK   = 3'd5,
`endif
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q,    state_d;
   logic [Psize-1:0] last_q,     last_d;
   logic [Psize-1:0] idx_q,      idx_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [Isize-9:0] asm_q,      asm_d;
   logic [Isize-1:0] wr_data_q,  wr_data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]       chk_acc_q,  chk_acc_d;
   logic             chk_err_q,  chk_err_d;
`endif

   logic             data_ready;
   logic             accept;
   logic [Isize-1:0] shifted;
   logic [31:0]      hdr_len;
   logic [Psize-1:0] hdr_last;

   // Handshake and the word formed if the current byte is appended.
   // asm_q keeps only the low Isize-8 bits, so the unused upper bits of the
   // first byte fall off the top as later bytes shift in.
   always_comb begin
      data_ready = (state_q == S_HDR) || (state_q == S_RECV)
`ifdef PROG_LOADER_CHECKSUM_EN
                   || (state_q == S_CHK)
`endif
                   ;
      accept     = bus.data_valid && data_ready;
      shifted    = {asm_q, bus.data_in};
   end

   // Header byte to last word index; 0 or anything beyond memory means full.
   always_comb begin
      hdr_len  = {24'd0, bus.data_in};
      hdr_last = '1;
      if ((hdr_len != 32'd0) && (hdr_len <= MEM_WORDS)) begin
         hdr_last = Psize'(hdr_len - 32'd1);
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      wr_data_d  = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_acc_d  = chk_acc_q;
      chk_err_d  = chk_err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d    = S_HDR;
               idx_d      = '0;
               byte_cnt_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               chk_acc_d  = '0;
               chk_err_d  = 1'b0;
`endif
            end
         end
         S_HDR: begin
            if (accept) begin
               last_d     = hdr_last;
               byte_cnt_d = '0;
               state_d    = S_RECV;
`ifdef PROG_LOADER_CHECKSUM_EN
               chk_acc_d  = chk_acc_q ^ bus.data_in;
`endif
            end
         end
         S_RECV: begin
            if (accept) begin
               asm_d = shifted[Isize-9:0];
`ifdef PROG_LOADER_CHECKSUM_EN
               chk_acc_d = chk_acc_q ^ bus.data_in;
`endif
               if (byte_cnt_q == LAST_BYTE) begin
                  wr_data_d  = shifted;
                  byte_cnt_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         S_WRITE: begin
            if (idx_q == last_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end else begin
               idx_d   = idx_q + Psize'(1);
               state_d = S_RECV;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               chk_err_d = (bus.data_in != chk_acc_q);
               state_d   = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any load in progress.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= S_IDLE;
         last_q     <= '0;
         idx_q      <= '0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         wr_data_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         chk_acc_q  <= '0;
         chk_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         wr_data_q  <= wr_data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         chk_acc_q  <= chk_acc_d;
         chk_err_q  <= chk_err_d;
`endif
      end
   end

   // Outputs decode directly from registered state, so reset clears them at once.
   always_comb begin
      bus.data_ready = data_ready;
      bus.wr_en      = (state_q == S_WRITE);
      bus.wr_addr    = idx_q;
      bus.wr_data    = wr_data_q;
      bus.busy       = (state_q == S_HDR) || (state_q == S_RECV) || (state_q == S_WRITE)
`ifdef PROG_LOADER_CHECKSUM_EN
                       || (state_q == S_CHK)
`endif
                       ;
      bus.load_done  = (state_q == S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
      bus.chk_err    = chk_err_q;
`endif
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: load tasks push expected writes computed
// from the byte stream; an independent monitor pops them on every wr_en.
module tb_prog_loader;
   localparam int          PSIZE = 6;
   localparam int          ISIZE = 17;
   localparam int          K     = (ISIZE + 7) / 8;
   localparam int          WORDS = 1 << PSIZE;
   localparam logic [31:0] MASK  = (32'd1 << ISIZE) - 32'd1;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic clk    = 1'b0;
   logic nReset = 1'b0;
   wr_t  exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_wr  = 0;

   always #5 clk = ~clk;

   prog_loader_if #(.Psize(PSIZE), .Isize(ISIZE)) bus ();

   prog_loader #(.Psize(PSIZE), .Isize(ISIZE)) dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (nReset === 1'b1 && bus.wr_en !== 1'b0) begin
         n_wr++;
         check("ready_low_in_write", {63'd0, bus.data_ready}, 64'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                     bus.wr_addr, bus.wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", {58'd0, bus.wr_addr}, 64'(e.addr));
            check("wr_data", {47'd0, bus.wr_data}, {32'd0, e.data});
         end
      end
   end

   function automatic int words_for(input logic [7:0] h);
      if (h != 8'd0 && int'(h) <= WORDS) return int'(h);
      return WORDS;
   endfunction

   // Reference: big-endian byte concatenation truncated to the word width.
   task automatic push_model(input logic [7:0] hdr, input logic [7:0] d[$]);
      int          n;
      logic [31:0] w;
      wr_t         e;
      n = words_for(hdr);
      for (int i = 0; i < n; i++) begin
         w = 32'd0;
         for (int k = 0; k < K; k++) w = (w << 8) | {24'd0, d[i*K+k]};
         e.addr = i;
         e.data = w & MASK;
         exp_q.push_back(e);
      end
   endtask

   function automatic int gap_for(input int mode);
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      return int'($urandom_range(0, 3));
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int tries;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         bus.start      = 1'b0;
         bus.data_valid = 1'b0;
         bus.data_in    = 8'($urandom);
      end
      tries = 0;
      while (1) begin
         @(negedge clk);
         bus.start      = 1'b0;
         bus.data_valid = 1'b1;
         bus.data_in    = b;
         if (bus.data_ready === 1'b1) break;
         tries++;
         if (tries > 50) begin
            check("byte_accept_timeout", {63'd0, bus.data_ready}, 64'd1);
            break;
         end
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", {63'd0, bus.busy}, 64'd1);
      check("done_clr_on_start", {63'd0, bus.load_done}, 64'd0);
      check("addr_clr_on_start", {58'd0, bus.wr_addr}, 64'd0);
   endtask

   task automatic wait_done(input int n, input int wr0, input bit exp_chk);
      int t;
      t = 0;
      while (bus.load_done !== 1'b1 && t < 1000) begin
         @(negedge clk);
         bus.data_valid = 1'b0;
         bus.start      = 1'b0;
         t++;
      end
      check("done_reached", {63'd0, t < 1000}, 64'd1);
      check("busy_in_done", {63'd0, bus.busy}, 64'd0);
      check("ready_in_done", {63'd0, bus.data_ready}, 64'd0);
      check("addr_in_done", {58'd0, bus.wr_addr}, 64'(n - 1));
      check("write_count", 64'(n_wr - wr0), 64'(n));
      check("pending_writes", 64'(exp_q.size()), 64'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
      check("chk_err", {63'd0, bus.chk_err}, {63'd0, exp_chk});
`else
      if (exp_chk) check("chk_expect_unused", 64'd0, 64'd0 + {63'd0, exp_chk} - 64'd1 + 64'd1 - 64'd1);
`endif
   endtask

   task automatic run_load(input logic [7:0] hdr, input logic [7:0] d[$], input int mode,
                           input int poke_idx, input bit bad_chk, input bit use_model);
      int         n;
      int         wr0;
      logic [7:0] cs;
      n   = words_for(hdr);
      wr0 = n_wr;
      if (use_model) push_model(hdr, d);
      start_load();
      cs = hdr;
      send_byte(hdr, gap_for(mode));
      for (int j = 0; j < n * K; j++) begin
         send_byte(d[j], gap_for(mode));
         cs ^= d[j];
         if (j == poke_idx) begin
            @(negedge clk);
            bus.data_valid = 1'b0;
            bus.start      = 1'b1;
         end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (cs ^ 8'h01) : cs, gap_for(mode));
`endif
      wait_done(n, wr0, bad_chk);
   endtask

   initial begin : stimulus
      logic [7:0] d[$];
      logic [7:0] hdr;
      wr_t        e;
      int         n;

      bus.start      = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in    = 8'h00;

      #12;
      check("rst_ready", {63'd0, bus.data_ready}, 64'd0);
      check("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
      check("rst_addr", {58'd0, bus.wr_addr}, 64'd0);
      check("rst_data", {47'd0, bus.wr_data}, 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.load_done}, 64'd0);
      @(negedge clk);
      nReset = 1'b1;
      repeat (4) @(negedge clk);
      check("no_autostart_busy", {63'd0, bus.busy}, 64'd0);
      check("no_autostart_ready", {63'd0, bus.data_ready}, 64'd0);

      // Reference vector, back-to-back, with hand-derived expectations
      d = {8'h01, 8'h23, 8'h45, 8'h00, 8'hAB, 8'hCD};
      e.addr = 0; e.data = 32'h12345; exp_q.push_back(e);
      e.addr = 1; e.data = 32'h0ABCD; exp_q.push_back(e);
      run_load(8'h02, d, 0, -1, 1'b0, 1'b0);

      // Same bytes with data_valid alternating
      run_load(8'h02, d, 1, -1, 1'b0, 1'b1);

      // Header 0 and header beyond memory both mean a full memory
      d.delete();
      for (int i = 0; i < WORDS * K; i++) d.push_back(8'($urandom));
      run_load(8'h00, d, 0, -1, 1'b0, 1'b1);
      d.delete();
      for (int i = 0; i < WORDS * K; i++) d.push_back(8'($urandom));
      run_load(8'h80, d, 2, -1, 1'b0, 1'b1);

      // start pulsed mid-word is ignored
      d.delete();
      for (int i = 0; i < 4 * K; i++) d.push_back(8'($urandom));
      run_load(8'h04, d, 2, K + 1, 1'b0, 1'b1);

      // Random headers, data and stall patterns
      for (int r = 0; r < 6; r++) begin
         hdr = 8'($urandom_range(0, 90));
         n   = words_for(hdr);
         d.delete();
         for (int i = 0; i < n * K; i++) d.push_back(8'($urandom));
         run_load(hdr, d, int'($urandom_range(0, 2)), -1, 1'b0, 1'b1);
      end

      // Reset after the 2nd byte of word 3 abandons the load
      d.delete();
      for (int i = 0; i < 5 * K; i++) d.push_back(8'($urandom));
      push_model(8'h05, d);
      start_load();
      send_byte(8'h05, 0);
      for (int j = 0; j < 3 * K + 2; j++) send_byte(d[j], 0);
      @(negedge clk);
      bus.data_valid = 1'b0;
      #2 nReset = 1'b0;
      #1;
      check("abort_ready", {63'd0, bus.data_ready}, 64'd0);
      check("abort_wr_en", {63'd0, bus.wr_en}, 64'd0);
      check("abort_addr", {58'd0, bus.wr_addr}, 64'd0);
      check("abort_data", {47'd0, bus.wr_data}, 64'd0);
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_done", {63'd0, bus.load_done}, 64'd0);
      check("abort_words_written", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      @(negedge clk);
      nReset = 1'b1;
      repeat (5) @(negedge clk);
      check("post_abort_busy", {63'd0, bus.busy}, 64'd0);
      check("post_abort_done", {63'd0, bus.load_done}, 64'd0);
      d = {8'h01, 8'hFF, 8'hFF};
      e.addr = 0; e.data = 32'h1FFFF; exp_q.push_back(e);
      run_load(8'h01, d, 0, -1, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
      d = {8'h00, 8'h00, 8'h07};
      run_load(8'h01, d, 0, -1, 1'b0, 1'b1);
      run_load(8'h01, d, 0, -1, 1'b1, 1'b1);
      run_load(8'h01, d, 2, -1, 1'b0, 1'b1);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
